// File: rtl/vga_timing_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : vga_timing_monitor                                        |
// | Description: Receive-side VGA timing checker. Recovers pixel           |
// |              coordinates from hsync/vsync/video_on, measures line and  |
// |              frame geometry, and reports lock and sticky errors.       |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       video_on,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_valid,
  output logic       locked,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       err_line,
  output logic       err_frame
);

  localparam logic [9:0] c_cnt_max     = 10'h3FF;
  localparam logic [9:0] c_h_total     = 10'(H_TOTAL);
  localparam logic [9:0] c_h_active    = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_total     = 10'(V_TOTAL);
  localparam logic [9:0] c_v_active    = 10'(V_ACTIVE);
  localparam logic [7:0] c_lock_frames = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_good_cnt;
  logic [7:0] w_good_nxt;
  logic       w_set_err_line;
  logic       w_set_err_frame;

  // Sampled sync levels; reset to 1 so a low input right after reset is a real edge.
  logic       r_hs;
  logic       r_vs;
  logic [9:0] r_h_cnt;
  logic [9:0] r_a_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] r_act_lines;
  logic       r_frame_bad;

  logic       w_hs_fall;
  logic       w_vs_fall;
  logic       w_h_sat;
  logic       w_line_bad;
  logic       w_frame_good;
  logic [9:0] w_line_len_new;
  logic [9:0] w_frame_lines_new;
  logic [9:0] w_act_final;

  assign w_hs_fall = r_hs & ~hsync;
  assign w_vs_fall = r_vs & ~vsync;
  assign locked    = (r_state == S_LOCKED);

  // Line/frame quality evaluated at the edges that close a line or a frame.
  always_comb begin
    w_h_sat           = (r_h_cnt == c_cnt_max);
    w_line_len_new    = w_h_sat ? c_cnt_max : (r_h_cnt + 10'd1);
    w_frame_lines_new = (r_v_cnt == c_cnt_max) ? c_cnt_max : (r_v_cnt + 10'd1);
    w_act_final       = r_act_lines;
    if (w_hs_fall && (r_a_cnt != 10'd0) && (r_act_lines != c_cnt_max)) begin
      w_act_final = r_act_lines + 10'd1;
    end
    w_line_bad = 1'b0;
    if (w_hs_fall) begin
      // A line closes here: period and active width must both match.
      w_line_bad = (w_line_len_new != c_h_total) ||
                   !((r_a_cnt == c_h_active) || (r_a_cnt == 10'd0));
    end else if (w_h_sat) begin
      // No hsync edge for 1024 clocks: treat the line as broken right away.
      w_line_bad = 1'b1;
    end
    // The line that ends on a coincident hsync edge still belongs to this frame.
    w_frame_good = (w_frame_lines_new == c_v_total) &&
                   (w_act_final == c_v_active) &&
                   !r_frame_bad && !w_line_bad;
  end

  // Measurement counters, sampled syncs and pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_h_cnt     <= '0;
      r_a_cnt     <= '0;
      r_v_cnt     <= '0;
      r_act_lines <= '0;
      r_frame_bad <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_hs        <= hsync;
      r_vs        <= vsync;
      frame_start <= w_vs_fall;
      rx_valid    <= video_on && (r_state == S_LOCKED);
      if (video_on) begin
        rx_x <= r_a_cnt;
        rx_y <= r_act_lines;
      end

      if (w_hs_fall) begin
        line_len <= w_line_len_new;
        r_h_cnt  <= '0;
        r_a_cnt  <= '0;
      end else begin
        if (!w_h_sat) begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
        if (video_on && (r_a_cnt != c_cnt_max)) begin
          r_a_cnt <= r_a_cnt + 10'd1;
        end
      end

      // Vertical bookkeeping; a vsync edge overrides a coincident hsync edge.
      if (w_vs_fall) begin
        frame_lines <= w_frame_lines_new;
        r_v_cnt     <= '0;
        r_act_lines <= '0;
        r_frame_bad <= 1'b0;
      end else begin
        if (w_hs_fall && (r_v_cnt != c_cnt_max)) begin
          r_v_cnt <= r_v_cnt + 10'd1;
        end
        r_act_lines <= w_act_final;
        if (w_line_bad) begin
          r_frame_bad <= 1'b1;
        end
      end
    end
  end

  // Lock state register, good-frame counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= '0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      if (w_set_err_line) begin
        err_line <= 1'b1;
      end
      if (w_set_err_frame) begin
        err_frame <= 1'b1;
      end
    end
  end

  // Next-state logic: search for a frame edge, count good frames, watch for faults.
  always_comb begin
    w_state_nxt     = r_state;
    w_good_nxt      = r_good_cnt;
    w_set_err_line  = 1'b0;
    w_set_err_frame = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_vs_fall) begin
          w_good_nxt  = '0;
          w_state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (w_vs_fall) begin
          if (w_frame_good) begin
            w_good_nxt = r_good_cnt + 8'd1;
            if (w_good_nxt >= c_lock_frames) begin
              w_state_nxt = S_LOCKED;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
      end
      S_LOCKED: begin
        if (w_line_bad) begin
          w_set_err_line = 1'b1;
          w_good_nxt     = '0;
          w_state_nxt    = S_SEARCH;
        end else if (w_vs_fall && !w_frame_good) begin
          w_set_err_frame = 1'b1;
          w_good_nxt      = '0;
          w_state_nxt     = S_SEARCH;
        end
      end
      default: begin
        w_good_nxt  = '0;
        w_state_nxt = S_SEARCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_vga_timing_monitor                                     |
// | Description: Bench for vga_timing_monitor using a reduced-size mode    |
// |              (64x30 total, 40x20 active) with VGA-style porches.       |
// | Revision   : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_vga_timing_monitor;

  localparam int HT     = 64;
  localparam int HA     = 40;
  localparam int HS_W   = 8;
  localparam int HBP    = 6;
  localparam int VT     = 30;
  localparam int VA     = 20;
  localparam int VS_W   = 2;
  localparam int VBP    = 3;
  localparam int H_ACT0 = HS_W + HBP;
  localparam int V_ACT0 = VS_W + VBP;

  localparam logic [9:0] HT10 = 10'(HT);
  localparam logic [9:0] VT10 = 10'(VT);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       video_on = 1'b0;
  logic [9:0] rx_x;
  logic [9:0] rx_y;
  logic       rx_valid;
  logic       locked;
  logic       frame_start;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       err_line;
  logic       err_frame;

  vga_timing_monitor #(
    .H_TOTAL    (HT),
    .H_ACTIVE   (HA),
    .V_TOTAL    (VT),
    .V_ACTIVE   (VA),
    .LOCK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .rx_x       (rx_x),
    .rx_y       (rx_y),
    .rx_valid   (rx_valid),
    .locked     (locked),
    .frame_start(frame_start),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .err_line   (err_line),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  int   checks = 0;
  int   errors = 0;
  int   h = 0;
  int   v = 0;
  bit   short_line = 1'b0;
  bit   short_frame = 1'b0;
  bit   prev_vs = 1'b1;
  bit   sb_en = 1'b0;
  pix_t sb_q[$];

  // One clock with explicit pin values; tracks expected frame_start and drains pixel scoreboard.
  task automatic tick_raw(input logic rs, input logic hs, input logic vs, input logic von,
                          output bit fell);
    bit   exp_fs;
    pix_t p;
    reset    = rs;
    hsync    = hs;
    vsync    = vs;
    video_on = von;
    exp_fs   = !rs && prev_vs && !vs;
    @(posedge clk);
    #1;
    prev_vs = rs ? 1'b1 : vs;
    fell    = exp_fs;
    checks++;
    if (frame_start !== exp_fs) begin
      errors++;
      $display("FAIL frame_start: got %b expected %b (h=%0d v=%0d)", frame_start, exp_fs, h, v);
    end
    if (sb_en && (rx_valid === 1'b1)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rx_pixel: got valid x=%0d y=%0d expected no pixel", rx_x, rx_y);
      end else begin
        p = sb_q.pop_front();
        if ((rx_x !== p.x) || (rx_y !== p.y)) begin
          errors++;
          $display("FAIL rx_pixel: got x=%0d y=%0d expected x=%0d y=%0d", rx_x, rx_y, p.x, p.y);
        end
      end
    end
  endtask

  // One clock of the reference stream at the current (h, v) position, then advance.
  task automatic tick(input logic rs, output bit fell);
    logic hs, vs, von;
    pix_t p;
    hs  = (h >= HS_W);
    vs  = (v >= VS_W);
    von = (h >= H_ACT0) && (h < H_ACT0 + HA) && (v >= V_ACT0) && (v < V_ACT0 + VA);
    if (sb_en && von) begin
      p.x = 10'(h - H_ACT0);
      p.y = 10'(v - V_ACT0);
      sb_q.push_back(p);
    end
    tick_raw(rs, hs, vs, von, fell);
    h++;
    if (h >= (short_line ? HT - 1 : HT)) begin
      h = 0;
      short_line = 1'b0;
      v++;
      if (v >= (short_frame ? VT - 1 : VT)) begin
        v = 0;
        short_frame = 1'b0;
      end
    end
  endtask

  task automatic tick_until(input int th, input int tv);
    bit f;
    int budget;
    budget = VT * HT + 1;
    while (!((h == th) && (v == tv)) && (budget > 0)) begin
      tick(1'b0, f);
      budget--;
    end
  endtask

  // Run the stream until n vsync falls have been driven; report lock activity before the last.
  task automatic run_to_falls(input int n, output bit saw_lock, output bit saw_unlock,
                              output bit timeout);
    bit f;
    int seen;
    int budget;
    seen       = 0;
    budget     = (n + 1) * VT * HT + 100;
    saw_lock   = 1'b0;
    saw_unlock = 1'b0;
    timeout    = 1'b0;
    while (seen < n) begin
      if (budget == 0) begin
        timeout = 1'b1;
        break;
      end
      budget--;
      tick(1'b0, f);
      if (f) seen++;
      if (seen < n) begin
        if (locked === 1'b1) saw_lock = 1'b1;
        else saw_unlock = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    bit f;
    h = 20;
    v = 10;
    repeat (3) tick(1'b1, f);
    checks++;
    if ({rx_x, rx_y, line_len, frame_lines} !== 40'd0) begin
      errors++;
      $display("FAIL reset_counts: got x=%0d y=%0d len=%0d lines=%0d expected all 0",
               rx_x, rx_y, line_len, frame_lines);
    end
    checks++;
    if ({rx_valid, locked, err_line, err_frame} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got valid/locked/errl/errf=%b%b%b%b expected 0000",
               rx_valid, locked, err_line, err_frame);
    end
  endtask

  task automatic test_lock;
    bit sl, su, to;
    run_to_falls(3, sl, su, to);
    checks++;
    if (to) begin errors++; $display("FAIL lock_timeout: got timeout expected 3 vsync falls"); end
    checks++;
    if (sl) begin errors++; $display("FAIL lock_early: got locked before 3rd fall expected 0"); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", locked); end
    checks++;
    if (line_len !== HT10) begin errors++; $display("FAIL lock_line_len: got %0d expected %0d", line_len, HT); end
    checks++;
    if (frame_lines !== VT10) begin errors++; $display("FAIL lock_frame_lines: got %0d expected %0d", frame_lines, VT); end
    checks++;
    if ({err_line, err_frame} !== 2'b00) begin
      errors++;
      $display("FAIL lock_errors: got %b%b expected 00", err_line, err_frame);
    end
  endtask

  task automatic test_pixels;
    bit f;
    int ph, pv;
    sb_q.delete();
    sb_en = 1'b1;
    for (int i = 0; i < VT * HT; i++) begin
      ph = h;
      pv = v;
      tick(1'b0, f);
      if ((pv == V_ACT0) && (ph == H_ACT0)) begin
        checks++;
        if ({rx_valid, rx_x, rx_y} !== {1'b1, 10'd0, 10'd0}) begin
          errors++;
          $display("FAIL first_pixel: got v=%b x=%0d y=%0d expected v=1 x=0 y=0", rx_valid, rx_x, rx_y);
        end
      end
      if ((pv == V_ACT0 + VA - 1) && (ph == H_ACT0 + HA - 1)) begin
        checks++;
        if ({rx_valid, rx_x, rx_y} !== {1'b1, 10'(HA - 1), 10'(VA - 1)}) begin
          errors++;
          $display("FAIL last_pixel: got v=%b x=%0d y=%0d expected v=1 x=%0d y=%0d",
                   rx_valid, rx_x, rx_y, HA - 1, VA - 1);
        end
      end
      if ((pv == V_ACT0 + VA - 1) && (ph == H_ACT0 + HA)) begin
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL blank_after_last: got %b expected 0", rx_valid); end
      end
    end
    sb_en = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pixel_drain: got %0d pixels unseen expected 0", sb_q.size());
    end
  endtask

  task automatic test_short_line;
    bit f, sl, su, to;
    tick_until(0, 10);
    short_line = 1'b1;
    repeat (HT - 1) tick(1'b0, f);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL short_pre_locked: got %b expected 1", locked); end
    tick(1'b0, f);
    checks++;
    if (line_len !== 10'(HT - 1)) begin errors++; $display("FAIL short_line_len: got %0d expected %0d", line_len, HT - 1); end
    checks++;
    if ({err_line, locked} !== 2'b10) begin
      errors++;
      $display("FAIL short_err: got err_line=%b locked=%b expected 1 0", err_line, locked);
    end
    run_to_falls(3, sl, su, to);
    checks++;
    if (to || sl || (locked !== 1'b1)) begin
      errors++;
      $display("FAIL short_relock: got timeout=%b early=%b locked=%b expected 0 0 1", to, sl, locked);
    end
    checks++;
    if (err_line !== 1'b1) begin errors++; $display("FAIL short_sticky: got %b expected 1", err_line); end
  endtask

  task automatic test_reset_midframe;
    bit f, sl, su, to;
    tick_until(30, 12);
    checks++;
    if ({locked, err_line} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre: got locked=%b err_line=%b expected 1 1", locked, err_line);
    end
    tick(1'b1, f);
    checks++;
    if ({locked, err_line, err_frame} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: got locked/errl/errf=%b%b%b expected 000", locked, err_line, err_frame);
    end
    run_to_falls(3, sl, su, to);
    checks++;
    if (to || sl || (locked !== 1'b1)) begin
      errors++;
      $display("FAIL rst_relock: got timeout=%b early=%b locked=%b expected 0 0 1", to, sl, locked);
    end
    checks++;
    if ({line_len, frame_lines} !== {HT10, VT10}) begin
      errors++;
      $display("FAIL rst_geometry: got len=%0d lines=%0d expected %0d %0d", line_len, frame_lines, HT, VT);
    end
  endtask

  task automatic test_stuck;
    bit f, sl, su, to;
    tick_until(0, 10);
    checks++;
    if ({locked, err_line} !== 2'b10) begin
      errors++;
      $display("FAIL stuck_pre: got locked=%b err_line=%b expected 1 0", locked, err_line);
    end
    repeat (HT) tick(1'b0, f);
    for (int s = 1; s <= 1100; s++) begin
      tick_raw(1'b0, 1'b1, 1'b1, 1'b0, f);
      if (s == 1023 - (HT - 1)) begin
        checks++;
        if ({locked, err_line} !== 2'b10) begin
          errors++;
          $display("FAIL stuck_before_sat: got locked=%b err_line=%b expected 1 0", locked, err_line);
        end
      end
      if (s == 1024 - (HT - 1)) begin
        checks++;
        if ({locked, err_line} !== 2'b01) begin
          errors++;
          $display("FAIL stuck_sat: got locked=%b err_line=%b expected 0 1", locked, err_line);
        end
        checks++;
        if (line_len !== HT10) begin errors++; $display("FAIL stuck_line_len: got %0d expected %0d", line_len, HT); end
      end
    end
    run_to_falls(3, sl, su, to);
    checks++;
    if (to || sl || (locked !== 1'b1)) begin
      errors++;
      $display("FAIL stuck_relock: got timeout=%b early=%b locked=%b expected 0 0 1", to, sl, locked);
    end
  endtask

  task automatic test_short_frame;
    bit sl, su, to;
    checks++;
    if (err_frame !== 1'b0) begin errors++; $display("FAIL frame_pre: got err_frame=%b expected 0", err_frame); end
    short_frame = 1'b1;
    run_to_falls(1, sl, su, to);
    checks++;
    if (to || su) begin
      errors++;
      $display("FAIL frame_hold: got timeout=%b unlocked_early=%b expected 0 0", to, su);
    end
    checks++;
    if (frame_lines !== 10'(VT - 1)) begin
      errors++;
      $display("FAIL frame_lines_short: got %0d expected %0d", frame_lines, VT - 1);
    end
    checks++;
    if ({err_frame, locked, err_line} !== 3'b101) begin
      errors++;
      $display("FAIL frame_err: got errf/locked/errl=%b%b%b expected 101", err_frame, locked, err_line);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_short_line();
    test_reset_midframe();
    test_stuck();
    test_short_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
